// File: rtl/mtc_thread_scheduler_pkg.sv
// Shared types and constants for the MTC thread scheduler: thread FSM states,
// process-channel field width and the "no thread" sentinel helper.
package mtc_thread_scheduler_pkg;

   typedef enum logic {
      THR_IDLE = 1'b0,
      THR_BUSY = 1'b1
   } thrState_t;

   localparam int PL2MTC_PROCESS_CH_LEN = 3;

   // The builder treats a process channel equal to the thread count as "no thread".
   function automatic logic [PL2MTC_PROCESS_CH_LEN-1:0] noThread(input int numThreads);
      return PL2MTC_PROCESS_CH_LEN'(numThreads);
   endfunction

endpackage

// File: rtl/mtc_thread_slot.sv
// One ptcalc thread slot: IDLE/BUSY occupancy FSM plus optional watchdog
// (watchdog present only when MTC_SCHED_TIMEOUT_EN is defined).
module mtc_thread_slot
   import mtc_thread_scheduler_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic clock,
   input  logic rst,
   input  logic i_grant,
   input  logic i_done,
`ifdef MTC_SCHED_TIMEOUT_EN
   output logic o_timeout,
`endif
   output logic o_busy
);

   thrState_t r_state;
   thrState_t w_stateNext;

`ifdef MTC_SCHED_TIMEOUT_EN
   localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   logic [WD_W-1:0] r_wdog;
   logic            w_expired;

   assign w_expired = (r_state == THR_BUSY) && (r_wdog == WD_W'(TIMEOUT_CYCLES));

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         r_wdog <= '0;
      end else if (i_grant) begin
         r_wdog <= '0;
      end else if ((r_state == THR_BUSY) && !w_expired) begin
         r_wdog <= r_wdog + 1'b1;
      end
   end
`endif

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         r_state <= THR_IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // A done pulse takes priority over watchdog expiry so a late-but-valid
   // completion is never counted as a timeout.
   always_comb begin
      w_stateNext = r_state;
`ifdef MTC_SCHED_TIMEOUT_EN
      o_timeout   = 1'b0;
`endif
      case (r_state)
         THR_IDLE: begin
            if (i_grant) begin
               w_stateNext = THR_BUSY;
            end
         end
         THR_BUSY: begin
            if (i_done) begin
               w_stateNext = THR_IDLE;
`ifdef MTC_SCHED_TIMEOUT_EN
            end else if (w_expired) begin
               w_stateNext = THR_IDLE;
               o_timeout   = 1'b1;
`endif
            end
         end
         default: w_stateNext = THR_IDLE;
      endcase
   end

   assign o_busy = (r_state == THR_BUSY);

endmodule

// File: rtl/mtc_thread_scheduler.sv
// Round-robin allocation of ptcalc threads to SL candidates, with drop and
// (optional, MTC_SCHED_TIMEOUT_EN) watchdog-timeout statistics.
module mtc_thread_scheduler
   import mtc_thread_scheduler_pkg::*;
#(
   parameter int c_NUM_THREADS  = 3,
   parameter int c_MAX_NUM_SL   = 3,
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                                                   clock,
   input  logic                                                   rst,
   input  logic [c_MAX_NUM_SL-1:0]                                slc_valid,
   input  logic [c_NUM_THREADS-1:0]                               thread_done,
   output logic [c_MAX_NUM_SL-1:0][PL2MTC_PROCESS_CH_LEN-1:0]     process_ch,
   output logic [c_MAX_NUM_SL-1:0]                                process_ch_valid,
   output logic [c_NUM_THREADS-1:0]                               thread_start,
   output logic [c_NUM_THREADS-1:0]                               thread_busy,
   output logic [CNT_WIDTH-1:0]                                   drop_cnt,
   output logic [CNT_WIDTH-1:0]                                   timeout_cnt
);

   localparam int RR_W   = (c_MAX_NUM_SL > 1) ? $clog2(c_MAX_NUM_SL) : 1;
   localparam int DROP_W = $clog2(c_MAX_NUM_SL + 1);
   localparam logic [PL2MTC_PROCESS_CH_LEN-1:0] c_NO_THREAD = noThread(c_NUM_THREADS);

   logic [RR_W-1:0]                                        r_rrPtr;
   logic [c_MAX_NUM_SL-1:0][PL2MTC_PROCESS_CH_LEN-1:0]     r_processCh;
   logic [c_MAX_NUM_SL-1:0]                                r_processChValid;
   logic [c_NUM_THREADS-1:0]                               r_threadStart;
   logic [CNT_WIDTH-1:0]                                   r_dropCnt;

   logic [c_NUM_THREADS-1:0]                               w_busy;
   logic [c_NUM_THREADS-1:0]                               w_free;
   logic [c_NUM_THREADS-1:0]                               w_grant;
   logic [c_MAX_NUM_SL-1:0][PL2MTC_PROCESS_CH_LEN-1:0]     w_chNext;
   logic [DROP_W-1:0]                                      w_drops;
   logic [RR_W:0]                                          w_sum;
   logic [RR_W-1:0]                                        w_idx;
   logic                                                   w_found;
   logic [CNT_WIDTH:0]                                     w_dropSum;

`ifdef MTC_SCHED_TIMEOUT_EN
   logic [c_NUM_THREADS-1:0] w_timeout;
`endif

   for (genvar t = 0; t < c_NUM_THREADS; t++) begin : g_slot
      mtc_thread_slot #(
         .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
      ) u_slot (
         .clock    (clock),
         .rst      (rst),
         .i_grant  (w_grant[t]),
         .i_done   (thread_done[t]),
`ifdef MTC_SCHED_TIMEOUT_EN
         .o_timeout(w_timeout[t]),
`endif
         .o_busy   (w_busy[t])
      );
   end

   // Grant pass: visit inputs from the round-robin pointer; each valid input
   // claims the lowest free thread. A thread freed this cycle still reads busy,
   // so it cannot be reused until the following cycle.
   always_comb begin
      w_grant  = '0;
      w_chNext = '0;
      w_drops  = '0;
      w_free   = ~w_busy;
      w_sum    = '0;
      w_idx    = '0;
      w_found  = 1'b0;
      for (int k = 0; k < c_MAX_NUM_SL; k++) begin
         w_sum = {1'b0, r_rrPtr} + (RR_W+1)'(k);
         if (w_sum >= (RR_W+1)'(c_MAX_NUM_SL)) begin
            w_sum = w_sum - (RR_W+1)'(c_MAX_NUM_SL);
         end
         w_idx   = w_sum[RR_W-1:0];
         w_found = 1'b0;
         if (slc_valid[w_idx]) begin
            for (int t = 0; t < c_NUM_THREADS; t++) begin
               if (!w_found && w_free[t]) begin
                  w_found         = 1'b1;
                  w_free[t]       = 1'b0;
                  w_grant[t]      = 1'b1;
                  w_chNext[w_idx] = PL2MTC_PROCESS_CH_LEN'(t);
               end
            end
            if (!w_found) begin
               w_chNext[w_idx] = c_NO_THREAD;
               w_drops         = w_drops + DROP_W'(1);
            end
         end
      end
   end

   assign w_dropSum = {1'b0, r_dropCnt} + (CNT_WIDTH+1)'(w_drops);

   // Registered grant results, round-robin pointer and saturating drop counter.
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         r_rrPtr          <= '0;
         r_processCh      <= '0;
         r_processChValid <= '0;
         r_threadStart    <= '0;
         r_dropCnt        <= '0;
      end else begin
         r_processCh      <= w_chNext;
         r_processChValid <= slc_valid;
         r_threadStart    <= w_grant;
         r_dropCnt        <= w_dropSum[CNT_WIDTH] ? '1 : w_dropSum[CNT_WIDTH-1:0];
         if (|slc_valid) begin
            r_rrPtr <= (r_rrPtr == RR_W'(c_MAX_NUM_SL - 1)) ? '0 : r_rrPtr + 1'b1;
         end
      end
   end

`ifdef MTC_SCHED_TIMEOUT_EN
   localparam int TO_W = $clog2(c_NUM_THREADS + 1);

   logic [CNT_WIDTH-1:0] r_timeoutCnt;
   logic [TO_W-1:0]      w_toCount;
   logic [CNT_WIDTH:0]   w_toSum;

   always_comb begin
      w_toCount = '0;
      for (int t = 0; t < c_NUM_THREADS; t++) begin
         w_toCount = w_toCount + TO_W'(w_timeout[t]);
      end
   end

   assign w_toSum = {1'b0, r_timeoutCnt} + (CNT_WIDTH+1)'(w_toCount);

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         r_timeoutCnt <= '0;
      end else begin
         r_timeoutCnt <= w_toSum[CNT_WIDTH] ? '1 : w_toSum[CNT_WIDTH-1:0];
      end
   end

   assign timeout_cnt = r_timeoutCnt;
`else
   assign timeout_cnt = '0;
`endif

   assign process_ch       = r_processCh;
   assign process_ch_valid = r_processChValid;
   assign thread_start     = r_threadStart;
   assign thread_busy      = w_busy;
   assign drop_cnt         = r_dropCnt;

endmodule

// File: tb/tb_mtc_thread_scheduler.sv
// Self-checking bench for mtc_thread_scheduler: table-driven vectors through a
// scoreboard queue plus hand-written reset and watchdog sequences.
module tb_mtc_thread_scheduler;

   logic              clock = 1'b0;
   logic              rst = 1'b0;
   logic [2:0]        slcValid = '0;
   logic [2:0]        threadDone = '0;
   logic [2:0][2:0]   processCh;
   logic [2:0]        processChValid;
   logic [2:0]        threadStart;
   logic [2:0]        threadBusy;
   logic [15:0]       dropCnt;
   logic [15:0]       timeoutCnt;

   int numCompared = 0;
   int numMismatched = 0;

   typedef struct {
      logic        resetFirst;
      logic [2:0]  valid;
      logic [2:0]  done;
      logic [8:0]  expCh;
      logic [2:0]  expPv;
      logic [2:0]  expStart;
      logic [2:0]  expBusy;
      logic [15:0] expDrop;
   } vec_t;

   vec_t vectors[$];
   vec_t expQ[$];

   mtc_thread_scheduler #(
      .c_NUM_THREADS (3),
      .c_MAX_NUM_SL  (3),
      .TIMEOUT_CYCLES(8),
      .CNT_WIDTH     (16)
   ) dut (
      .clock           (clock),
      .rst             (rst),
      .slc_valid       (slcValid),
      .thread_done     (threadDone),
      .process_ch      (processCh),
      .process_ch_valid(processChValid),
      .thread_start    (threadStart),
      .thread_busy     (threadBusy),
      .drop_cnt        (dropCnt),
      .timeout_cnt     (timeoutCnt)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      numCompared++;
      if (act !== exp) begin
         numMismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic checkAllZero(input string tag);
      check({tag, "_ch"},    32'(processCh),      32'h0);
      check({tag, "_pv"},    32'(processChValid), 32'h0);
      check({tag, "_start"}, 32'(threadStart),    32'h0);
      check({tag, "_busy"},  32'(threadBusy),     32'h0);
      check({tag, "_drop"},  32'(dropCnt),        32'h0);
      check({tag, "_tmo"},   32'(timeoutCnt),     32'h0);
   endtask

   // Synchronous-looking reset pulse, released just after a rising edge.
   task automatic doReset();
      rst        = 1'b1;
      slcValid   = '0;
      threadDone = '0;
      @(posedge clock);
      #1;
      checkAllZero("reset");
      rst = 1'b0;
   endtask

   task automatic applyStimulus(input vec_t v);
      slcValid   = v.valid;
      threadDone = v.done;
      expQ.push_back(v);
   endtask

   task automatic checkOutput(input int step);
      vec_t e;
      string s;
      if (expQ.size() == 0) begin
         numCompared++;
         numMismatched++;
         $display("[TB] FAIL scoreboard_empty: got 0 entries, expected 1 at step %0d", step);
         return;
      end
      e = expQ.pop_front();
      s = $sformatf("v%0d", step);
      check({s, "_ch"},    32'(processCh),      32'(e.expCh));
      check({s, "_pv"},    32'(processChValid), 32'(e.expPv));
      check({s, "_start"}, 32'(threadStart),    32'(e.expStart));
      check({s, "_busy"},  32'(threadBusy),     32'(e.expBusy));
      check({s, "_drop"},  32'(dropCnt),        32'(e.expDrop));
      check({s, "_tmo"},   32'(timeoutCnt),     32'h0);
   endtask

   function automatic vec_t mk(input logic r, input logic [2:0] v, input logic [2:0] d,
                               input logic [8:0] ch, input logic [2:0] pv, input logic [2:0] st,
                               input logic [2:0] b, input logic [15:0] dr);
      vec_t x;
      x.resetFirst = r;
      x.valid      = v;
      x.done       = d;
      x.expCh      = ch;
      x.expPv      = pv;
      x.expStart   = st;
      x.expBusy    = b;
      x.expDrop    = dr;
      return x;
   endfunction

   initial begin
      // expCh packs {ch[2], ch[1], ch[0]}, 3 bits each; 3 is the no-thread sentinel.
      vectors.push_back(mk(1'b0, 3'b001, 3'b000, 9'b000_000_000, 3'b001, 3'b001, 3'b001, 16'd0));
      vectors.push_back(mk(1'b0, 3'b000, 3'b001, 9'b000_000_000, 3'b000, 3'b000, 3'b000, 16'd0));
      vectors.push_back(mk(1'b0, 3'b111, 3'b000, 9'b001_000_010, 3'b111, 3'b111, 3'b111, 16'd0));
      vectors.push_back(mk(1'b0, 3'b011, 3'b000, 9'b000_011_011, 3'b011, 3'b000, 3'b111, 16'd2));
      vectors.push_back(mk(1'b0, 3'b001, 3'b010, 9'b000_000_011, 3'b001, 3'b000, 3'b101, 16'd3));
      vectors.push_back(mk(1'b0, 3'b001, 3'b000, 9'b000_000_001, 3'b001, 3'b010, 3'b111, 16'd3));
      vectors.push_back(mk(1'b0, 3'b000, 3'b111, 9'b000_000_000, 3'b000, 3'b000, 3'b000, 16'd3));
      vectors.push_back(mk(1'b0, 3'b100, 3'b010, 9'b000_000_000, 3'b100, 3'b001, 3'b001, 16'd3));
      vectors.push_back(mk(1'b0, 3'b110, 3'b000, 9'b010_001_000, 3'b110, 3'b110, 3'b111, 16'd3));
      vectors.push_back(mk(1'b0, 3'b111, 3'b000, 9'b011_011_011, 3'b111, 3'b000, 3'b111, 16'd6));
      vectors.push_back(mk(1'b1, 3'b111, 3'b000, 9'b010_001_000, 3'b111, 3'b111, 3'b111, 16'd0));
      vectors.push_back(mk(1'b0, 3'b111, 3'b000, 9'b011_011_011, 3'b111, 3'b000, 3'b111, 16'd3));
      vectors.push_back(mk(1'b0, 3'b011, 3'b100, 9'b000_011_011, 3'b011, 3'b000, 3'b011, 16'd5));

      doReset();

      for (int i = 0; i < vectors.size(); i++) begin
         if (vectors[i].resetFirst) begin
            doReset();
         end
         applyStimulus(vectors[i]);
         @(posedge clock);
         #1;
         checkOutput(i);
      end
      slcValid   = '0;
      threadDone = '0;

      // Asynchronous reset mid-cycle with two threads busy and drop_cnt at 5.
      #2;
      rst = 1'b1;
      #1;
      checkAllZero("async_rst");
      @(posedge clock);
      #1;
      rst = 1'b0;
      applyStimulus(mk(1'b0, 3'b000, 3'b011, 9'd0, 3'b000, 3'b000, 3'b000, 16'd0));
      @(posedge clock);
      #1;
      checkOutput(100);
      threadDone = '0;

`ifdef MTC_SCHED_TIMEOUT_EN
      // Watchdog expiry without done, then done arriving on the expiry cycle.
      doReset();
      slcValid = 3'b001;
      @(posedge clock);
      #1;
      slcValid = '0;
      check("wd1_busy_start", 32'(threadBusy[0]), 32'h1);
      for (int j = 2; j <= 9; j++) begin
         @(posedge clock);
         #1;
         check($sformatf("wd1_busy_%0d", j), 32'(threadBusy[0]), 32'h1);
      end
      @(posedge clock);
      #1;
      check("wd1_busy_end", 32'(threadBusy[0]), 32'h0);
      check("wd1_tmo", 32'(timeoutCnt), 32'h1);

      slcValid = 3'b001;
      @(posedge clock);
      #1;
      slcValid = '0;
      check("wd2_busy_start", 32'(threadBusy[0]), 32'h1);
      for (int j = 2; j <= 9; j++) begin
         @(posedge clock);
         #1;
      end
      threadDone = 3'b001;
      @(posedge clock);
      #1;
      threadDone = '0;
      check("wd2_busy_end", 32'(threadBusy[0]), 32'h0);
      check("wd2_tmo", 32'(timeoutCnt), 32'h1);
`else
      // Without the watchdog a thread stays busy indefinitely until done.
      doReset();
      slcValid = 3'b001;
      @(posedge clock);
      #1;
      slcValid = '0;
      repeat (20) @(posedge clock);
      #1;
      check("nowd_busy", 32'(threadBusy[0]), 32'h1);
      check("nowd_tmo", 32'(timeoutCnt), 32'h0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
      $finish;
   end

endmodule

// File: doc/mtc_thread_scheduler.md
# mtc_thread_scheduler

Allocates pT-calculation threads to sector-logic candidates arriving on the SL pipeline inputs and writes the chosen thread index into each candidate's process-channel field before the MTC builder consumes it. Tracks per-thread occupancy, frees threads on completion, and counts candidates dropped for lack of a free thread. Sits between the SLC pipeline and the ptcalc threads, upstream of the MTC builder, so that builder's `ptcalc[process_ch]` lookup always points at the right thread.

## Interface
Parameters:
- `c_NUM_THREADS`, 3, number of ptcalc threads (1..7)
- `c_MAX_NUM_SL`, 3, number of SL candidate inputs per cycle (1..7)
- `TIMEOUT_CYCLES`, 255, watchdog limit per busy thread (used only with `MTC_SCHED_TIMEOUT_EN`)
- `CNT_WIDTH`, 16, width of the statistics counters

Ports:
- `clock`  in  1  sole clock
- `rst`  in  1  asynchronous, active-high reset
- `slc_valid`  in  `[c_MAX_NUM_SL]`  candidate present on SL input i this cycle
- `thread_done`  in  `[c_NUM_THREADS]`  single-cycle completion pulse from ptcalc thread t
- `process_ch`  out  `[c_MAX_NUM_SL][PL2MTC_PROCESS_CH_LEN]`  assigned thread, or `c_NUM_THREADS` if none
- `process_ch_valid`  out  `[c_MAX_NUM_SL]`  registered copy of `slc_valid`
- `thread_start`  out  `[c_NUM_THREADS]`  single-cycle launch pulse to thread t
- `thread_busy`  out  `[c_NUM_THREADS]`  thread t occupied
- `drop_cnt`  out  `CNT_WIDTH`  candidates that received no thread; saturating
- `timeout_cnt`  out  `CNT_WIDTH`  watchdog releases; saturating; tied to 0 without the macro

## Operation
- Each thread has a two-state FSM:
  - IDLE → BUSY on grant.
  - BUSY → IDLE on `thread_done[t]`, or on watchdog expiry when `MTC_SCHED_TIMEOUT_EN` is defined.
- Grant pass, every cycle:
  - Visit SL inputs starting at `rr_ptr`, wrapping modulo `c_MAX_NUM_SL`.
  - Each valid input takes the lowest-index thread that is IDLE and not already granted this cycle.
  - Multiple grants per cycle are allowed, up to the number of IDLE threads.
- Granted input i: `process_ch[i]` = thread index; `thread_start[t]` = 1.
- Ungranted valid input: `process_ch[i]` = `c_NUM_THREADS`; `drop_cnt` += 1 for each such input in the cycle.
- Round-robin pointer: `rr_ptr` advances by 1 (wrapping) in any cycle with at least one valid input; otherwise it holds.
- Invalid inputs: `process_ch` = 0 and no grant.
- `thread_done` on an IDLE thread is ignored.
- Counters stop at all-ones; they do not wrap.

## Timing
- Reset values: all `process_ch`, `process_ch_valid`, `thread_start`, `thread_busy`, `drop_cnt`, `timeout_cnt`, and `rr_ptr` are 0; every thread is IDLE.
- Latency: `slc_valid` at cycle N → `process_ch`, `process_ch_valid`, `thread_start`, and `thread_busy` rise at N+1 (all registered).
- Release: `thread_done[t]` at cycle M → `thread_busy[t]` falls at M+1. A candidate presented at M+1 can take thread t; its grant appears at M+2. A thread is never reused in the same cycle it is freed.
- Watchdog: the counter is cleared on grant and increments every BUSY cycle. When it reaches `TIMEOUT_CYCLES` with no done pulse, the thread returns to IDLE the next cycle and `timeout_cnt` += 1.
- `thread_done` coinciding with watchdog expiry counts as done; `timeout_cnt` does not increment.
- `rst` asserted mid-operation clears everything immediately, with no completion handling. In-flight threads are forgotten, and late `thread_done` pulses are ignored.

## Configuration
- `MTC_SCHED_TIMEOUT_EN` defined: per-thread watchdog counters present; `timeout_cnt` active.
- Undefined: no watchdog logic. A thread leaves BUSY only on `thread_done` or `rst`. `timeout_cnt` is constant 0.

## Structure
- Shared package holds:
  - the thread-state enum (`THR_IDLE`, `THR_BUSY`)
  - the no-thread sentinel constant (equal to `c_NUM_THREADS`)
  - the width constant `PL2MTC_PROCESS_CH_LEN`
- One sub-module, `mtc_thread_slot`, instantiated `c_NUM_THREADS` times. It contains:
  - the FSM
  - the watchdog counter
  - `busy`, `timeout` pulse, and `grant`/`done` inputs
- Grant pass, round-robin pointer, and counters live in the top module.

## Test plan
- Reset, then `slc_valid`=3'b001 at N → at N+1: `process_ch[0]`=0, `thread_start`=3'b001, `thread_busy`=3'b001.
- All three inputs valid with `rr_ptr`=1 and all threads IDLE → `process_ch[1]`=0, `process_ch[2]`=1, `process_ch[0]`=2; `drop_cnt` stays 0.
- All threads BUSY, two inputs valid → both `process_ch`=3; `drop_cnt` increases by 2.
- `thread_done[1]` at M with input 0 valid at M → input 0 gets the sentinel (3); input 0 valid again at M+1 → `process_ch[0]`=1 at M+2.
- With `MTC_SCHED_TIMEOUT_EN` and `TIMEOUT_CYCLES`=8, grant thread 0 and never send done → `thread_busy[0]` falls after the expiry cycle and `timeout_cnt`=1. Repeat with done on the expiry cycle → `timeout_cnt` unchanged.
- Assert `rst` while two threads are BUSY and `drop_cnt`=5 → all outputs 0 immediately; a late `thread_done` causes no change.
